wb_slave_mem: RTL
=================

WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 Parameter aw, 16, Wishbone address width in bits.
REQ-002 Parameter dw, 32, data width; only 32 is supported.
REQ-003 Parameter mem_aw, 8, word-address bits, giving a depth of 2^mem_aw 32-bit words.
REQ-004 Parameter WS, 1, wait states inserted before each response (range 0..15).
REQ-005 CLK_I  in  1  sole clock; all logic on rising edge.
REQ-006 RST_I  in  1  reset, synchronous, active-high.
REQ-007 CYC_I  in  1  bus cycle valid.
REQ-008 STB_I  in  1  transfer strobe.
REQ-009 WE_I  in  1  1=write, 0=read.
REQ-010 ADR_I  in  aw  byte address; word index = ADR_I[mem_aw+1:2].
REQ-011 SEL_I  in  4  byte lane enables; lane i = DAT bits 8i+7:8i.
REQ-012 DAT_I  in  32  write data.
REQ-013 TAG_I  in  4  request tag.
REQ-014 RTY_REQ_I  in  1  test control: answer the next request with RTY_O.
REQ-015 DAT_O  out  32  read data, registered.
REQ-016 ACK_O  out  1  normal termination, one-cycle pulse.
REQ-017 ERR_O  out  1  error termination, one-cycle pulse.
REQ-018 RTY_O  out  1  retry termination, one-cycle pulse.
REQ-019 TAG_O  out  4  TAG_I latched at request acceptance; valid with the response.

Function
REQ-020 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-021 IDLE: when CYC_I&STB_I is sampled high, the block SHALL latch ADR_I, WE_I, SEL_I, DAT_I and TAG_I, load the wait counter with WS, and go to WAIT if WS>0, else RESP.
REQ-022 WAIT: the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the cycle the counter reaches 1.
REQ-023 WAIT: if CYC_I or STB_I is sampled low, the transfer SHALL be aborted: go to IDLE, no write, no termination pulse.
REQ-024 Latency: with the request sampled at edge E0, exactly one of ACK_O/ERR_O/RTY_O SHALL be high for the single cycle following edge E0+WS.
REQ-025 RESP SHALL last exactly one cycle, then return to IDLE unconditionally; back-to-back beats therefore have at least one idle cycle, matching a master that drops STB after each ACK.
REQ-026 Termination priority SHALL be RTY (RTY_REQ_I sampled high at E0) over ERR (latched ADR_I[aw-1:mem_aw+2] nonzero or ADR_I[1:0] nonzero) over ACK.
REQ-027 Write with ACK: the memory SHALL be updated on the edge entering RESP, only for lanes with SEL_I set; lanes with SEL_I clear SHALL be unchanged; SEL_I=0000 SHALL be acked with no change.
REQ-028 Read with ACK: DAT_O SHALL present the full word (SEL_I ignored) during the ACK cycle and SHALL hold that value until the next read ACK.
REQ-029 ERR and RTY terminations SHALL NOT modify memory or DAT_O.
REQ-030 Termination outputs SHALL never be high while the FSM is not in RESP, and at most one SHALL be high in any cycle.
REQ-031 Changes on ADR_I/DAT_I/SEL_I/WE_I after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-032 CYC_I low with STB_I high SHALL be ignored.
REQ-033 The word index SHALL be computed without wrap-around; any address beyond the depth SHALL take the ERR path.

Reset
REQ-034 While RST_I is high at an edge: FSM = IDLE, wait counter = 0, ACK_O = ERR_O = RTY_O = 0, DAT_O = 0, TAG_O = 0.
REQ-035 Memory contents SHALL NOT be reset or cleared.
REQ-036 Reset during WAIT or RESP SHALL drop the transfer, suppress any pending termination, and leave memory unwritten if the write had not yet reached RESP.

Verification
REQ-037 WS=1: write 0xDEADBEEF to 0x0010, SEL 1111 -> ACK_O high exactly 2 cycles after acceptance; a read of 0x0010 returns 0xDEADBEEF.
REQ-038 Byte lanes: preload 0x11223344 at 0x0020, write 0xAABBCCDD with SEL 0101 -> a read returns 0x11BB33DD.
REQ-039 Address 0x0400 (beyond 256 words) write -> ERR_O single pulse, no ACK_O, DAT_O unchanged, no memory aliasing at 0x0000.
REQ-040 RTY_REQ_I=1 on a read of 0x0010 -> RTY_O single pulse, DAT_O unchanged; the retry with RTY_REQ_I=0 -> ACK_O with 0xDEADBEEF.
REQ-041 WS=3, STB_I dropped 1 cycle after acceptance of a write -> no termination pulse, memory unchanged, next request served normally.
REQ-042 RST_I asserted during WAIT of a write to 0x0030 -> all outputs 0 next cycle; a read of 0x0030 after reset returns its prior contents; TAG_I=0xA read returns TAG_O=0xA with ACK_O.

Source files
------------

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave wrapped around a word-organised memory.
// Each accepted beat waits WS cycles, then terminates with exactly one of
// ACK/ERR/RTY for a single cycle. Out-of-range or misaligned addresses
// take the ERR path. RTY_REQ_I forces a retry termination for test use.
module wb_slave_mem #(
    parameter int aw     = 16,
    parameter int dw     = 32,
    parameter int mem_aw = 8,
    parameter int WS     = 1
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic          WE_I,
    input  logic [aw-1:0] ADR_I,
    input  logic [3:0]    SEL_I,
    input  logic [dw-1:0] DAT_I,
    input  logic [3:0]    TAG_I,
    input  logic          RTY_REQ_I,
    output logic [dw-1:0] DAT_O,
    output logic          ACK_O,
    output logic          ERR_O,
    output logic          RTY_O,
    output logic [3:0]    TAG_O
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH   = 1 << mem_aw;
    localparam logic [3:0] WS_LOAD = 4'(WS);

    // Storage; deliberately never reset so contents survive RST_I.
    logic [dw-1:0] mem [0:DEPTH-1];

    // Control state.
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        rty_q, rty_d;
    logic [3:0]  tag_q, tag_d;
    logic [dw-1:0] dat_o_q;

    // Request fields captured at acceptance.
    logic [aw-1:0] adr_q, adr_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [dw-1:0] wdat_q, wdat_d;
    logic          rty_req_q, rty_req_d;

    // Strobes for the edge that enters RESP.
    logic              enter_resp;
    logic              mem_we;
    logic              rd_en;
    logic [mem_aw-1:0] widx;

    // An address is bad if any bit above the memory window is set or it is
    // not word aligned; no modulo wrap onto lower words.
    function automatic logic addr_err(input logic [aw-1:0] adr);
        return (|(adr >> (mem_aw + 2))) | (|adr[1:0]);
    endfunction

    // Word index taken from the (possibly just-latched) request address.
    assign widx = adr_d[mem_aw+1:2];

    // Next-state, request latching and termination selection.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        rty_req_d  = rty_req_q;
        tag_d      = tag_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rty_d      = 1'b0;
        enter_resp = 1'b0;
        mem_we     = 1'b0;
        rd_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (CYC_I && STB_I) begin
                    adr_d     = ADR_I;
                    we_d      = WE_I;
                    sel_d     = SEL_I;
                    wdat_d    = DAT_I;
                    rty_req_d = RTY_REQ_I;
                    tag_d     = TAG_I;
                    cnt_d     = WS_LOAD;
                    if (WS_LOAD == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!(CYC_I && STB_I)) begin
                    // Master gave up: drop the beat silently.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    cnt_d      = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Termination priority: retry, then error, then normal ack.
        if (enter_resp) begin
            if (rty_req_d) begin
                rty_d = 1'b1;
            end else if (addr_err(adr_d)) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (we_d) begin
                    mem_we = 1'b1;
                end else begin
                    rd_en = 1'b1;
                end
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            tag_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            tag_q   <= tag_d;
        end
    end

    // Latched request fields; only meaningful after an acceptance.
    always_ff @(posedge CLK_I) begin
        adr_q     <= adr_d;
        we_q      <= we_d;
        sel_q     <= sel_d;
        wdat_q    <= wdat_d;
        rty_req_q <= rty_req_d;
    end

    // Read data register: loads only on a read ACK and holds otherwise.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            dat_o_q <= '0;
        end else if (rd_en) begin
            dat_o_q <= mem[widx];
        end
    end

    // Byte-lane write on the edge entering RESP; reset blocks the write.
    always_ff @(posedge CLK_I) begin
        if (mem_we && !RST_I) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_d[i]) begin
                    mem[widx][8*i +: 8] <= wdat_d[8*i +: 8];
                end
            end
        end
    end

    assign DAT_O = dat_o_q;
    assign ACK_O = ack_q;
    assign ERR_O = err_q;
    assign RTY_O = rty_q;
    assign TAG_O = tag_q;

endmodule
